// File: rtl/wrdata_line_fifo.sv
// wrdata_line_fifo: packs IN_WIDTH host words into LINE_WIDTH burst lines and buffers them in a
// DEPTH-entry show-ahead FIFO. Define WRDATA_REPLICATE_EN to add single-word replicated line fill.
module wrdata_line_fifo #(
    parameter int LINE_WIDTH = 512,
    parameter int IN_WIDTH   = 32,
    parameter int DEPTH      = 4,
    parameter int PTR_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_WIDTH-1:0]   in_data,
    input  logic                  in_last,
`ifdef WRDATA_REPLICATE_EN
    input  logic                  in_replicate,
`endif
    input  logic                  wrdata_fifo_rd,
    output logic                  wrdata_fifo_empty,
    output logic [LINE_WIDTH-1:0] wrdata_fifo_data,
    output logic [PTR_WIDTH:0]    fill_level,
    output logic                  underflow_err
);

    localparam int WORDS = LINE_WIDTH / IN_WIDTH;
    localparam int CNT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(WORDS - 1);
    localparam logic [PTR_WIDTH:0] FULL_LVL = (PTR_WIDTH + 1)'(DEPTH);

    logic [CNT_W-1:0]      word_cnt_r;
    logic [LINE_WIDTH-1:0] asm_r;
    logic [LINE_WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr_r;
    logic [PTR_WIDTH-1:0]  rd_ptr_r;
    logic [PTR_WIDTH:0]    fill_r;
    logic                  empty_r;
    logic                  underflow_r;

    logic                  replicate_s;
    logic                  commit_cond_s;
    logic                  in_ready_s;
    logic                  accept_s;
    logic                  commit_s;
    logic                  pop_s;
    logic [LINE_WIDTH-1:0] line_s;
    logic [PTR_WIDTH:0]    fill_nxt_s;

`ifdef WRDATA_REPLICATE_EN
    assign replicate_s = in_replicate && (word_cnt_r == {CNT_W{1'b0}});
`else
    assign replicate_s = 1'b0;
`endif

    // A committing word never uses a same-cycle pop to get past a full FIFO, keeping ready off the pop path.
    assign commit_cond_s = (word_cnt_r == LAST_IDX) || in_last || replicate_s;
    assign in_ready_s    = rst || !((fill_r == FULL_LVL) && commit_cond_s);
    assign accept_s      = in_valid && in_ready_s;
    assign commit_s      = accept_s && commit_cond_s && !rst;
    assign pop_s         = wrdata_fifo_rd && !empty_r;

    assign in_ready          = in_ready_s;
    assign wrdata_fifo_empty = empty_r;
    assign wrdata_fifo_data  = mem_r[rd_ptr_r];
    assign fill_level        = fill_r;
    assign underflow_err     = underflow_r;

    // Merge the incoming word into the assembly image; unwritten slots stay zero from the last clear.
    always_comb begin
        line_s = asm_r;
        if (replicate_s) begin
            line_s = {WORDS{in_data}};
        end else begin
            for (int k = 0; k < WORDS; k++) begin
                if (word_cnt_r == CNT_W'(k)) begin
                    line_s[k*IN_WIDTH +: IN_WIDTH] = in_data;
                end else begin
                    line_s[k*IN_WIDTH +: IN_WIDTH] = asm_r[k*IN_WIDTH +: IN_WIDTH];
                end
            end
        end
    end

    // Next fill level: commit and pop in the same cycle cancel out.
    always_comb begin
        fill_nxt_s = fill_r;
        if (commit_s && !pop_s) begin
            fill_nxt_s = fill_r + (PTR_WIDTH + 1)'(1);
        end else if (!commit_s && pop_s) begin
            fill_nxt_s = fill_r - (PTR_WIDTH + 1)'(1);
        end else begin
            fill_nxt_s = fill_r;
        end
    end

    // Word packing, FIFO pointers, occupancy and sticky underflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_r  <= {CNT_W{1'b0}};
            asm_r       <= {LINE_WIDTH{1'b0}};
            wr_ptr_r    <= {PTR_WIDTH{1'b0}};
            rd_ptr_r    <= {PTR_WIDTH{1'b0}};
            fill_r      <= {(PTR_WIDTH + 1){1'b0}};
            empty_r     <= 1'b1;
            underflow_r <= 1'b0;
        end else begin
            if (commit_s) begin
                word_cnt_r <= {CNT_W{1'b0}};
                asm_r      <= {LINE_WIDTH{1'b0}};
                wr_ptr_r   <= wr_ptr_r + PTR_WIDTH'(1);
            end else if (accept_s) begin
                word_cnt_r <= word_cnt_r + CNT_W'(1);
                asm_r      <= line_s;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_WIDTH'(1);
            end
            if (wrdata_fifo_rd && empty_r) begin
                underflow_r <= 1'b1;
            end
            fill_r  <= fill_nxt_s;
            empty_r <= (fill_nxt_s == {(PTR_WIDTH + 1){1'b0}});
        end
    end

    // Line storage; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (commit_s) begin
            mem_r[wr_ptr_r] <= line_s;
        end
    end

endmodule

// File: tb/tb_wrdata_line_fifo.sv
// Self-checking bench for wrdata_line_fifo: queue-based line model compared every cycle,
// plus directed literal expectations for packing order, padding, stall, wrap, underflow and reset.
module tb_wrdata_line_fifo;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  in_data = 32'h0;
    logic         in_last = 1'b0;
    logic         tb_rep = 1'b0;
    logic         rd = 1'b0;
    logic         empty;
    logic [511:0] data;
    logic [2:0]   fill;
    logic         uf;

`ifdef WRDATA_REPLICATE_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    wrdata_line_fifo dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .in_last          (in_last),
`ifdef WRDATA_REPLICATE_EN
        .in_replicate     (tb_rep),
`endif
        .wrdata_fifo_rd   (rd),
        .wrdata_fifo_empty(empty),
        .wrdata_fifo_data (data),
        .fill_level       (fill),
        .underflow_err    (uf)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Behavioural model: a queue of committed lines plus the words of the partial line.
    logic [511:0] q[$];
    logic [31:0]  mw[16];
    int           m_cnt = 0;
    bit           m_uf = 1'b0;
    bit           m_acc = 1'b0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [511:0] ln;
        bit rep_now, cc, rdy;
        forever begin
            @(posedge clk);
            if (rst) begin
                q.delete();
                m_cnt = 0;
                m_uf  = 1'b0;
                m_acc = 1'b0;
                for (int k = 0; k < 16; k++) mw[k] = 32'h0;
            end else begin
                rep_now = REP_EN && tb_rep && (m_cnt == 0);
                cc      = (m_cnt == 15) || in_last || rep_now;
                rdy     = !((q.size() == DEPTH) && cc);
                m_acc   = in_valid && rdy;
                if (rd) begin
                    if (q.size() > 0) void'(q.pop_front());
                    else m_uf = 1'b1;
                end
                if (m_acc) begin
                    if (rep_now) begin
                        ln = {16{in_data}};
                        q.push_back(ln);
                        m_cnt = 0;
                    end else begin
                        mw[m_cnt] = in_data;
                        if (cc) begin
                            ln = '0;
                            for (int k = 0; k <= m_cnt; k++) ln[k*32 +: 32] = mw[k];
                            q.push_back(ln);
                            m_cnt = 0;
                            for (int k = 0; k < 16; k++) mw[k] = 32'h0;
                        end else begin
                            m_cnt++;
                        end
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        bit exp_rdy;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                exp_rdy = rst ? 1'b1 :
                          !((q.size() == DEPTH) &&
                            ((m_cnt == 15) || in_last || (REP_EN && tb_rep && (m_cnt == 0))));
                check("in_ready", 512'(in_ready), 512'(exp_rdy));
                check("empty", 512'(empty), 512'(q.size() == 0));
                check("fill_level", 512'(fill), 512'(q.size()));
                check("underflow", 512'(uf), 512'(m_uf));
                if (q.size() > 0) check("data", data, q[0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, input logic last, input logic r);
        bit acc;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tb_rep   = r;
        acc      = 1'b0;
        for (int t = 0; t < 40 && !acc; t++) begin
            tick();
            acc = m_acc;
        end
        if (!acc) begin
            n_chk++;
            n_err++;
            $display("FAIL send_timeout: word %h not accepted within 40 cycles", d);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        tb_rep   = 1'b0;
    endtask

    task automatic send_line(input logic [31:0] base);
        for (int k = 0; k < 16; k++) send_word(base + 32'(k), 1'b0, 1'b0);
    endtask

    initial begin
        logic [511:0] exp_l;
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_empty", 512'(empty), 512'(1'b1));
        check("rst_fill", 512'(fill), 512'(3'd0));
        check("rst_ready", 512'(in_ready), 512'(1'b1));

        // Line 0..15: order and commit latency
        for (int k = 0; k < 15; k++) send_word(32'(k), 1'b0, 1'b0);
        check("A_empty_before", 512'(empty), 512'(1'b1));
        send_word(32'hF, 1'b0, 1'b0);
        check("A_empty_fall", 512'(empty), 512'(1'b0));
        check("A_word0", 512'(data[31:0]), 512'(32'h0));
        check("A_word15", 512'(data[511:480]), 512'(32'hF));
        check("A_fill", 512'(fill), 512'(3'd1));
        check("model_A_word15", 512'(q[0][511:480]), 512'(32'hF));

        // Short line with in_last, committed on the same edge as a pop at fill 1
        send_word(32'hA, 1'b0, 1'b0);
        send_word(32'hB, 1'b0, 1'b0);
        rd = 1'b1;
        send_word(32'hC, 1'b1, 1'b0);
        rd = 1'b0;
        exp_l = '0;
        exp_l[95:0] = {32'hC, 32'hB, 32'hA};
        check("B_fill", 512'(fill), 512'(3'd1));
        check("B_line", data, exp_l);
        check("B_no_uf", 512'(uf), 512'(1'b0));

        // Drain then underflow
        rd = 1'b1;
        tick();
        check("drain_empty", 512'(empty), 512'(1'b1));
        tick();
        rd = 1'b0;
        check("uf_set", 512'(uf), 512'(1'b1));
        tick();
        tick();
        check("uf_sticky", 512'(uf), 512'(1'b1));
        check("uf_fill", 512'(fill), 512'(3'd0));

        // Five lines: fill to DEPTH, stall on line 5 word 15, pop does not bypass
        for (int n = 1; n <= 4; n++) send_line(32'(n) << 8);
        check("full_fill", 512'(fill), 512'(3'd4));
        check("full_head", 512'(data[31:0]), 512'(32'h100));
        for (int k = 0; k < 15; k++) send_word(32'h500 + 32'(k), 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 32'h50F;
        tick();
        check("stall_ready", 512'(in_ready), 512'(1'b0));
        check("stall_fill", 512'(fill), 512'(3'd4));
        rd = 1'b1;
        tick();
        rd = 1'b0;
        check("nobypass_fill", 512'(fill), 512'(3'd3));
        check("nobypass_ready", 512'(in_ready), 512'(1'b1));
        tick();
        in_valid = 1'b0;
        check("line5_fill", 512'(fill), 512'(3'd4));
        for (int n = 2; n <= 5; n++) begin
            check("wrap_w0", 512'(data[31:0]), 512'((32'(n) << 8)));
            check("wrap_w15", 512'(data[511:480]), 512'((32'(n) << 8) + 32'hF));
            rd = 1'b1;
            tick();
            rd = 1'b0;
        end
        check("wrap_empty", 512'(empty), 512'(1'b1));

        // Reset mid-line discards the partial line and the sticky flag
        for (int k = 0; k < 7; k++) send_word(32'hBAD0 + 32'(k), 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_empty", 512'(empty), 512'(1'b1));
        check("mrst_fill", 512'(fill), 512'(3'd0));
        check("mrst_uf", 512'(uf), 512'(1'b0));
        send_line(32'h600);
        for (int k = 0; k < 16; k++) exp_l[k*32 +: 32] = 32'h600 + 32'(k);
        check("mrst_clean_line", data, exp_l);
        rd = 1'b1;
        tick();
        rd = 1'b0;

`ifdef WRDATA_REPLICATE_EN
        send_word(32'hDEADBEEF, 1'b0, 1'b1);
        exp_l = {16{32'hDEADBEEF}};
        check("replicate_line", data, exp_l);
        check("replicate_fill", 512'(fill), 512'(3'd1));
        rd = 1'b1;
        tick();
        rd = 1'b0;
`endif

        tick();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/wrdata_line_fifo.md
Name: wrdata_line_fifo

Overview:
- Upstream neighbour of the instruction dispatcher's write path.
- Packs a 32-bit host write-data stream (from the instruction-sequence receiver) into 512-bit burst lines.
- Buffers the lines in a small FIFO.
- Presents the lines on a show-ahead interface (rd / empty / data) that the dispatcher pops once per DDR write burst.

Parameters:
- IN_WIDTH, 32, width of one host data word.
- LINE_WIDTH, 512, width of one burst line; must be an integer multiple of IN_WIDTH (16 words at defaults).
- DEPTH, 4, number of buffered lines; power of two, at least 2.
- PTR_WIDTH, 2, log2(DEPTH).

Ports:
- clk  input  1  system clock; the block uses a single clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a host word is offered.
- in_ready  output  1  the block can accept the offered word.
- in_data  input  IN_WIDTH  host data word.
- in_last  input  1  the accepted word closes the current line; unused words are zero-padded.
- wrdata_fifo_rd  input  1  pop the head line; sampled at the clock edge.
- wrdata_fifo_empty  output  1  no line is available.
- wrdata_fifo_data  output  LINE_WIDTH  head line; valid whenever empty is low.
- fill_level  output  PTR_WIDTH+1  number of committed lines, 0 to DEPTH.
- underflow_err  output  1  sticky; set by a pop attempted while empty.

Behaviour:
- Handshake: a word is accepted on a clock edge where in_valid and in_ready are both high.
- Holding in_valid with in_ready low is legal; the word, data and in_last must stay stable until accepted.
- Packing: word counter word_cnt runs 0 to 15.
  - The accepted word k is written to assembly-register bits [32k+31 : 32k], so word 0 is the LSBs.
  - This matches the dispatcher's slice order: beat 0 is [127:0], and so on.
- Commit: the line is committed on the edge that accepts word 15, or any word with in_last = 1.
  - On commit, the line is written to mem[wr_ptr], wr_ptr increments, and word_cnt returns to 0.
  - If in_last arrives at word_cnt = j < 15, words j+1..15 are forced to 0.
  - The assembly register is cleared after every commit.
- in_ready = NOT (fifo full AND the accepted word would commit).
  - Words 0..14 without in_last are always accepted.
  - A committing word waits while fill_level = DEPTH.
  - A pop in the same cycle does not unblock the wait (no bypass); this is deliberate, for timing.
- Pop: when wrdata_fifo_rd = 1 and empty = 0, rd_ptr increments at the edge.
  - When wrdata_fifo_rd = 1 and empty = 1, there is no pointer change and underflow_err is set.
- wrdata_fifo_data = mem[rd_ptr], read combinationally from a registered array.
  - It changes only on a pop, or when the first line arrives into an empty FIFO.
- wrdata_fifo_empty is computed from the registered fill_level.
  - A line committed at edge N is visible (empty = 0) after edge N, i.e. one cycle of commit-to-visible latency.
- fill_level update per edge: +1 on commit only, -1 on valid pop only, unchanged on both or neither.
- Simultaneous commit and pop at fill_level = 1 leaves fill_level at 1, and data becomes the new line.
- Pointers wrap modulo DEPTH. fill_level never exceeds DEPTH and never goes below 0.
- Reset takes effect at any point, including mid-line. Reset values:
  - word_cnt = 0, wr_ptr = rd_ptr = 0, assembly register = 0.
  - fill_level = 0, wrdata_fifo_empty = 1, underflow_err = 0.
  - in_ready = 1 during and after reset.
  - Partial lines and buffered lines are discarded. Memory contents are don't-care.
- Sequencing: no state machine beyond word_cnt. The block is always ready to accept except for the full/commit condition.

Optional Feature:
- Macro: WRDATA_REPLICATE_EN.
- With the macro defined:
  - Adds input in_replicate (1 bit).
  - A word accepted with in_replicate = 1 and word_cnt = 0 commits a full line made of that word repeated 16 times.
  - in_last is ignored in that case.
  - The word obeys the same full/in_ready rule as a committing word.
  - in_replicate = 1 with word_cnt ≠ 0 is treated as a normal word; replication is ignored.
- Without the macro: the port does not exist, and lines are built only from packed words.

Test Plan:
- Reset, then 16 words 0x00000000..0x0000000F with no stalls → empty falls one cycle after word 15; data[31:0] = 0x0, data[511:480] = 0xF; fill_level = 1.
- 3 words 0xA, 0xB, 0xC with in_last on 0xC → line = {416'b0, 0xC, 0xB, 0xA}; word_cnt back to 0.
- Push 5 full lines with no pops → fill_level = 4; in_ready low at word 15 of line 5 and held through a same-cycle pop; after the pop, line 5 is accepted on the next cycle; data order across wrap = lines 1..5.
- With fill_level = 1, commit and pop on the same edge → fill_level stays 1; data switches to the new line; no underflow.
- Pop while empty → underflow_err = 1 and remains set; pointers unchanged; cleared only by rst.
- Assert rst after 7 words of a line → empty = 1, fill_level = 0; the next 16 words form a clean line with no stale data. With WRDATA_REPLICATE_EN, one replicated word 0xDEADBEEF → line = 16 × 0xDEADBEEF.
